// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the parametrised sequence detector
package seq_det_pkg;

  localparam logic [4:0] DEF_PAT_5  = 5'b10110;
  localparam int         DEF_LEN_5  = 5;
  localparam int         MASK_MAX_W = 64;

  function automatic logic len_ok(input int unsigned len_in, input int unsigned pat_w);
    return (len_in >= 32'd1) && (len_in <= pat_w);
  endfunction

  // mask[i] = 1 for every bit position that belongs to the active pattern
  function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
    logic [MASK_MAX_W-1:0] m;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// rtl/seq_det_cmp.sv - combinational masked compare of history against the active pattern
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic [PAT_W-1:0] hist,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             eq
);

  logic [PAT_W-1:0] mask;

  always_comb begin
    mask = PAT_W'(len_mask(32'(len)));
    eq   = ((hist ^ pat) & mask) == '0;
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable serial pattern detector with overlap control
// Optional saturating match counter enabled by SEQDET_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = $clog2(PAT_W) + 1,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_5),
  parameter int               DEF_LEN = DEF_LEN_5,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             j_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             w,
  output logic [LEN_W-1:0] fill,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             w_q, w_d;
  logic             cfg_err_q, cfg_err_d;

  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W:0]   fill_inc;
  logic             eq;
  logic             hit;

  // Compare against the history as it will look once the incoming bit is shifted in
  seq_det_cmp #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_cmp (
    .hist (hist_shift),
    .pat  (pat_q),
    .len  (len_q),
    .eq   (eq)
  );

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], j};
    fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
    hit        = j_valid && !pat_load && eq && (fill_inc >= {1'b0, len_q});

    hist_d    = hist_q;
    pat_d     = pat_q;
    len_d     = len_q;
    fill_d    = fill_q;
    cfg_err_d = cfg_err_q;
    w_d       = 1'b0;

    if (pat_load) begin
      if (len_ok(32'(len_in), 32'(PAT_W))) begin
        pat_d  = pat_in;
        len_d  = len_in;
        fill_d = '0;
        hist_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (j_valid) begin
      hist_d = hist_shift;
      fill_d = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
      w_d    = hit;
      // Non-overlapping mode forgets the history that produced the match
      if (hit && !overlap) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q    <= '0;
      pat_q     <= DEF_PAT;
      len_q     <= LEN_W'(DEF_LEN);
      fill_q    <= '0;
      w_q       <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      w_q       <= w_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign w       = w_q;
  assign fill    = fill_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - table-driven bench for seq_detector_param
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             j;
  logic             j_valid;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             w;
  logic [LEN_W-1:0] fill;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .j         (j),
    .j_valid   (j_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .w         (w),
    .fill      (fill),
    .cfg_err   (cfg_err),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, j, jv, ov, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       w;
    int         fill;
    logic       err;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic jj, logic jv, logic ov, logic ld, logic [7:0] p,
                              logic [3:0] l, logic ew, int ef, logic ee, int ec);
    vec_t v;
    v.rst = r; v.j = jj; v.jv = jv; v.ov = ov; v.ld = ld; v.pat = p; v.len = l;
    v.w = ew; v.fill = ef; v.err = ee; v.cnt = ec;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst();
    add(0, 1, 1, 1, 1, 8'hFF, 4'd3, 0, 0, 0, 0);
  endfunction

  function automatic void add_bit(logic jj, logic ov, logic ew, int ef, logic ee, int ec);
    add(1, jj, 1, ov, 0, 8'h00, 4'd0, ew, ef, ee, ec);
  endfunction

  function automatic void add_idle(logic jj, int ef, logic ee, int ec);
    add(1, jj, 0, 1, 0, 8'h00, 4'd0, 0, ef, ee, ec);
  endfunction

  function automatic void add_load(logic [7:0] p, logic [3:0] l, int ef, logic ee, int ec);
    add(1, 1, 1, 1, 1, p, l, 0, ef, ee, ec);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_exp(int c);
`ifdef SEQDET_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic step(logic r, logic jj, logic jv, logic ov, logic ld, logic [7:0] p, logic [3:0] l);
    rst = r; j = jj; j_valid = jv; overlap = ov; pat_load = ld; pat_in = p; len_in = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; j = 0; j_valid = 0; overlap = 1; pat_load = 0; pat_in = '0; len_in = '0;

    // Default 10110, overlapping
    add_rst();
    add_bit(1,1,0,1,0,0); add_bit(0,1,0,2,0,0); add_bit(1,1,0,3,0,0); add_bit(1,1,0,4,0,0);
    add_bit(0,1,1,5,0,1); add_bit(1,1,0,5,0,1); add_bit(1,1,0,5,0,1); add_bit(0,1,1,5,0,2);
    // Same stream, non-overlapping
    add_rst();
    add_bit(1,0,0,1,0,0); add_bit(0,0,0,2,0,0); add_bit(1,0,0,3,0,0); add_bit(1,0,0,4,0,0);
    add_bit(0,0,1,0,0,1); add_bit(1,0,0,1,0,1); add_bit(1,0,0,2,0,1); add_bit(0,0,0,3,0,1);
    // 111 pattern, overlapping then non-overlapping
    add_rst();
    add_load(8'hFF, 4'd3, 0, 0, 0);
    add_bit(1,1,0,1,0,0); add_bit(1,1,0,2,0,0); add_bit(1,1,1,3,0,1);
    add_bit(1,1,1,3,0,2); add_bit(1,1,1,3,0,3); add_bit(1,1,1,3,0,4);
    add_load(8'hFF, 4'd3, 0, 0, 4);
    add_bit(1,0,0,1,0,4); add_bit(1,0,0,2,0,4); add_bit(1,0,1,0,0,5);
    add_bit(1,0,0,1,0,5); add_bit(1,0,0,2,0,5); add_bit(1,0,1,0,0,6);
    // Idle gaps between accepted bits
    add_rst();
    add_bit(1,1,0,1,0,0); add_idle(0,1,0,0); add_bit(0,1,0,2,0,0); add_idle(1,2,0,0);
    add_bit(1,1,0,3,0,0); add_idle(0,3,0,0); add_idle(0,3,0,0); add_bit(1,1,0,4,0,0);
    add_idle(0,4,0,0); add_bit(0,1,1,5,0,1); add_idle(0,5,0,1); add_idle(1,5,0,1);
    // Illegal lengths leave config and history alone, bit ignored during load
    add_rst();
    add_bit(1,1,0,1,0,0); add_bit(0,1,0,2,0,0);
    add_load(8'hFF, 4'd0, 2, 1, 0); add_load(8'hFF, 4'd9, 2, 1, 0);
    add_bit(1,1,0,3,1,0); add_bit(1,1,0,4,1,0); add_bit(0,1,1,5,1,1); add_idle(0,5,1,1);
    // Reset mid-stream
    add_rst();
    add_bit(1,1,0,1,0,0); add_bit(0,1,0,2,0,0); add_bit(1,1,0,3,0,0); add_bit(1,1,0,4,0,0);
    add_rst();
    add_bit(0,1,0,1,0,0); add_bit(1,1,0,2,0,0); add_bit(0,1,0,3,0,0); add_bit(1,1,0,4,0,0);
    add_bit(1,1,0,5,0,0); add_bit(0,1,1,5,0,1);
    // len=1 and full-length pattern
    add_rst();
    add_load(8'h00, 4'd1, 0, 0, 0);
    add_bit(0,1,1,1,0,1); add_bit(1,1,0,1,0,1); add_bit(0,1,1,1,0,2);
    add_bit(0,0,1,0,0,3); add_bit(0,0,1,0,0,4); add_bit(1,0,0,1,0,4);
    add_load(8'hA5, 4'd8, 0, 0, 4);
    add_bit(1,1,0,1,0,4); add_bit(0,1,0,2,0,4); add_bit(1,1,0,3,0,4); add_bit(0,1,0,4,0,4);
    add_bit(0,1,0,5,0,4); add_bit(1,1,0,6,0,4); add_bit(0,1,0,7,0,4); add_bit(1,1,1,8,0,5);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].j, vecs[i].jv, vecs[i].ov, vecs[i].ld, vecs[i].pat, vecs[i].len);
      check($sformatf("v%0d_w", i), int'(w), int'(vecs[i].w));
      check($sformatf("v%0d_fill", i), int'(fill), vecs[i].fill);
      check($sformatf("v%0d_cfg_err", i), int'(cfg_err), int'(vecs[i].err));
      check($sformatf("v%0d_cnt", i), int'(match_cnt), cnt_exp(vecs[i].cnt));
    end

    // Toggling overlap while idle keeps fill; the later match reuses old history
    step(0, 0, 0, 1, 0, 8'h00, 4'd0);
    step(1, 1, 1, 1, 0, 8'h00, 4'd0);
    step(1, 0, 1, 1, 0, 8'h00, 4'd0);
    step(1, 1, 1, 1, 0, 8'h00, 4'd0);
    step(1, 1, 1, 1, 0, 8'h00, 4'd0);
    step(1, 0, 1, 1, 0, 8'h00, 4'd0);
    check("ovl_first_w", int'(w), 1);
    step(1, 0, 0, 0, 0, 8'h00, 4'd0);
    check("ovl_idle_fill", int'(fill), 5);
    check("ovl_idle_w", int'(w), 0);
    step(1, 1, 1, 0, 0, 8'h00, 4'd0);
    step(1, 1, 1, 0, 0, 8'h00, 4'd0);
    step(1, 0, 1, 0, 0, 8'h00, 4'd0);
    check("ovl_second_w", int'(w), 1);
    check("ovl_second_fill", int'(fill), 0);
    step(1, 1, 1, 0, 0, 8'h00, 4'd0);
    check("ovl_after_w", int'(w), 0);

`ifdef SEQDET_COUNT_EN
    // Counter saturation at all-ones
    step(0, 0, 0, 1, 0, 8'h00, 4'd0);
    step(1, 0, 0, 1, 1, 8'h01, 4'd1);
    for (int k = 0; k < 20; k++) step(1, 1, 1, 1, 0, 8'h00, 4'd0);
    check("cnt_sat", int'(match_cnt), 15);
    check("cnt_sat_w", int'(w), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
